// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Iterative integer multiply/divide unit for the LoongArch
//             MUL.W / MULH.W / MULH.WU / DIV.W / MOD.W / DIV.WU / MOD.WU family.
//             Radix-2 shift-add multiply and restoring divide, one bit per
//             cycle, with a valid/ready request and response handshake.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             req_valid/req_ready request handshake
//             req_op/a/b/tag      operation, sources, destination tag
//             flush               abort any in-flight operation
//             resp_valid/ready    response handshake
//             resp_data/tag       result and its destination tag
//             busy                high whenever not IDLE
//  Revision : 1.0  initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [WIDTH-1:0]   c_ONE      = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_PROD_ONE = (2*WIDTH)'(1);

    localparam logic [2:0] c_OP_MUL_W   = 3'd0;
    localparam logic [2:0] c_OP_MULH_W  = 3'd1;
    localparam logic [2:0] c_OP_MULH_WU = 3'd2;
    localparam logic [2:0] c_OP_DIV_W   = 3'd3;
    localparam logic [2:0] c_OP_MOD_W   = 3'd4;
    localparam logic [2:0] c_OP_DIV_WU  = 3'd5;
    localparam logic [2:0] c_OP_MOD_WU  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [TAG_W-1:0]   r_tag;
    logic               r_a_neg;
    logic               r_b_neg;
    logic [WIDTH-1:0]   r_a_mag;     // multiplicand / dividend magnitude
    logic [WIDTH-1:0]   r_b_mag;     // divisor magnitude
    logic [2*WIDTH-1:0] r_prod;      // upper: partial sum, lower: remaining multiplier bits
    logic [WIDTH:0]     r_rem;       // partial remainder
    logic [WIDTH-1:0]   r_quo;       // dividend bits shift out, quotient bits shift in
    logic [c_CNT_W-1:0] r_cnt;

    // ---------------- request decode: magnitudes and signs ----------------
    logic             w_req_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_req_signed = (req_op == c_OP_MULH_W) || (req_op == c_OP_DIV_W) ||
                          (req_op == c_OP_MOD_W);
    assign w_a_neg = w_req_signed & req_a[WIDTH-1];
    assign w_b_neg = w_req_signed & req_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~req_a + c_ONE) : req_a;
    assign w_b_mag = w_b_neg ? (~req_b + c_ONE) : req_b;

    // ---------------- multiply step ----------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_next;

    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                         (r_prod[0] ? {1'b0, r_a_mag} : {(WIDTH+1){1'b0}});
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    // ---------------- restoring divide step ----------------
    // The remainder is always below the divisor, so the shifted value fits in
    // WIDTH+1 bits; the extra top bit only serves as the borrow detector.
    logic [WIDTH+1:0] w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_ge;

    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {2'b00, r_b_mag};
    assign w_div_ge    = ~w_div_diff[WIDTH+1];

    // ---------------- sign fix-up and result select ----------------
    logic               w_sign_diff;
    logic               w_div_zero;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_result;

    assign w_sign_diff = r_a_neg ^ r_b_neg;
    assign w_div_zero  = (r_b_mag == '0);
    assign w_prod_fix  = w_sign_diff ? (~r_prod + c_PROD_ONE) : r_prod;
    // Divide by zero yields all ones regardless of signedness; the raw
    // magnitude quotient would otherwise be negated for a negative dividend.
    assign w_quo_fix   = w_div_zero  ? '1 :
                         w_sign_diff ? (~r_quo + c_ONE) : r_quo;
    assign w_rem_fix   = r_a_neg ? (~r_rem[WIDTH-1:0] + c_ONE) : r_rem[WIDTH-1:0];

    always_comb begin
        w_result = '0;
        case (r_op)
            c_OP_MUL_W:                w_result = w_prod_fix[WIDTH-1:0];
            c_OP_MULH_W, c_OP_MULH_WU: w_result = w_prod_fix[2*WIDTH-1:WIDTH];
            c_OP_DIV_W,  c_OP_DIV_WU:  w_result = w_quo_fix;
            c_OP_MOD_W,  c_OP_MOD_WU:  w_result = w_rem_fix;
            default:                   w_result = '0;
        endcase
    end

    // ---------------- control and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_tag      <= '0;
            r_a_neg    <= 1'b0;
            r_b_neg    <= 1'b0;
            r_a_mag    <= '0;
            r_b_mag    <= '0;
            r_prod     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            // Aborts work in flight and blocks acceptance in IDLE.
            r_state    <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_tag     <= req_tag;
                        r_a_neg   <= w_a_neg;
                        r_b_neg   <= w_b_neg;
                        r_a_mag   <= w_a_mag;
                        r_b_mag   <= w_b_mag;
                        r_prod    <= {{WIDTH{1'b0}}, w_b_mag};
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_cnt     <= c_CNT_INIT;
                        r_state   <= S_CALC;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_CALC: begin
                    // Both datapaths step together; the op picks one at FIX.
                    // The counter-exhausted cycle keeps the total latency fixed.
                    if (r_cnt != '0) begin
                        r_prod <= w_prod_next;
                        r_rem  <= w_div_ge ? w_div_diff[WIDTH:0] : w_div_shift[WIDTH:0];
                        r_quo  <= {r_quo[WIDTH-2:0], w_div_ge};
                        r_cnt  <= r_cnt - c_CNT_ONE;
                    end else begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    resp_data  <= w_result;
                    resp_tag   <= r_tag;
                    resp_valid <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Self-checking bench for mdu_iter: directed vector table,
//             randomized operations against an arithmetic reference model,
//             back-pressure, flush and mid-operation reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_iter;

    localparam int c_LAT = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mdu_iter #(.WIDTH(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Reference model straight from the instruction semantics.
    function automatic logic [31:0] ref_model(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = ua * ub; return p[63:32]; end
            3'd3: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd4: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the response, check latency/data/tag,
    // complete the handshake and check the return to IDLE.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input string name);
        int lat;
        chk({name, ".ready"}, {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({name, ".lat"}, 64'(lat), 64'(c_LAT));
        chk({name, ".data"}, {32'b0, resp_data}, {32'b0, exp});
        chk({name, ".tag"}, {59'b0, resp_tag}, {59'b0, tag});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({name, ".idle"}, {61'b0, resp_valid, req_ready, busy}, {61'b0, 3'b010});
    endtask

    // Start an op, then abort it in CALC cycle at_cycle with flush or rst.
    task automatic abort_run(input bit use_rst, input int at_cycle, input string name);
        int seen;
        req_valid = 1'b1; req_op = 3'd3; req_a = 32'd1000; req_b = 32'd7; req_tag = 5'd21;
        tick();
        req_valid = 1'b0;
        repeat (at_cycle - 1) tick();
        chk({name, ".busy"}, {63'b0, busy}, 64'd1);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        chk({name, ".idle"}, {61'b0, resp_valid, req_ready, busy}, {61'b0, 3'b010});
        if (use_rst)
            chk({name, ".clr"}, {27'b0, resp_data, resp_tag}, 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (resp_valid || busy) seen++;
        end
        chk({name, ".noresp"}, 64'(seen), 64'd0);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{3'd3, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[5]  = '{3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC};
        vecs[6]  = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF};
        vecs[7]  = '{3'd4, 32'd100,        32'd0,         32'd100};
        vecs[8]  = '{3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{3'd3, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
        vecs[11] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
        vecs[12] = '{3'd7, 32'd12345,      32'd678,       32'h0000_0000};
        vecs[13] = '{3'd1, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF};

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        chk("reset", {26'b0, req_ready, resp_valid, busy, resp_tag, resp_data},
            {26'b0, 3'b100, 5'd0, 32'd0});

        // Directed vector table (first entry is the MUL_W latency case, tag 9)
        for (int i = 0; i < 14; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i == 0) ? 5'd9 : 5'(i),
                   vecs[i].exp, $sformatf("vec%0d", i));

        // Back-pressure in DONE, with a competing request held high
        begin
            int          lat;
            logic [31:0] exp;
            exp = ref_model(3'd3, 32'd1000, 32'hFFFF_FFF9);
            req_valid = 1'b1; req_op = 3'd3; req_a = 32'd1000; req_b = 32'hFFFF_FFF9; req_tag = 5'd17;
            tick();
            req_tag = 5'd3;
            lat = 0;
            while (!resp_valid && lat < 100) begin tick(); lat++; end
            chk("bp.lat", 64'(lat), 64'(c_LAT));
            for (int c = 0; c < 10; c++) begin
                chk($sformatf("bp.hold%0d", c),
                    {25'b0, resp_valid, req_ready, busy, resp_tag, resp_data},
                    {25'b0, 3'b101, 5'd17, exp});
                tick();
            end
            resp_ready = 1'b1;
            tick();
            req_valid = 1'b0; resp_ready = 1'b0;
            chk("bp.release", {61'b0, resp_valid, req_ready, busy}, {61'b0, 3'b010});
            tick();
            chk("bp.noaccept", {63'b0, busy}, 64'd0);
        end

        // Flush in IDLE together with a request: not accepted
        req_valid = 1'b1; flush = 1'b1; req_op = 3'd0; req_a = 32'd3; req_b = 32'd4; req_tag = 5'd1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        chk("idleflush", {62'b0, req_ready, busy}, {62'b0, 2'b10});

        // Flush at CALC cycle 5, then a normal op; rst at CALC cycle 20, then a normal op
        abort_run(1'b0, 5, "flush5");
        run_op(3'd0, 32'd6, 32'd7, 5'd4, 32'd42, "postflush");
        abort_run(1'b1, 20, "rst20");
        run_op(3'd6, 32'd50, 32'd7, 5'd5, 32'd1, "postrst");

        // Randomized operations against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [31:0] pick [4];
            op = 3'($urandom_range(0, 7));
            pick[0] = 32'd0; pick[1] = 32'h8000_0000; pick[2] = 32'hFFFF_FFFF; pick[3] = $urandom;
            a = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            run_op(op, a, b, 5'($urandom), ref_model(op, a, b), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
